// File: rtl/pcie_link_pkg.sv
// Shared definitions for the PCIe link channel model.
//   SYMWIDTH          : width of one 10b-encoded lane symbol
//   IDLE_SYM          : symbol driven on a lane while it is electrically idle
//   MAXDELAY_DEFAULT  : default depth of each per-direction delay line
//   TAPWIDTH          : width of the runtime tap select (matches the Delay port)
//   inj_state_t       : error-injection FSM state encoding
package pcie_link_pkg;

  localparam int SYMWIDTH = 10;
  localparam logic [SYMWIDTH-1:0] IDLE_SYM = 10'h000;
  localparam int MAXDELAY_DEFAULT = 8;
  localparam int TAPWIDTH = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_INJECT = 2'd1,
    ST_WAIT   = 2'd2
  } inj_state_t;

endpackage

// File: rtl/pcie_link_delay_line.sv
// One direction of the link channel: a MAXDELAY-deep shift register of lane
// symbols and electrical-idle flags with a runtime output tap.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_sym      : NUMLANES symbols entering stage 0
//   i_idle     : NUMLANES idle flags entering stage 0
//   i_tap      : stage index driven to the outputs (already clamped by caller)
//   o_sym      : tapped symbols, forced to IDLE_SYM on idle lanes
//   o_idle     : tapped idle flags
module pcie_link_delay_line
  import pcie_link_pkg::*;
#(
  parameter int NUMLANES = 16,
  parameter int MAXDELAY = MAXDELAY_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUMLANES*SYMWIDTH-1:0] i_sym,
  input  logic [NUMLANES-1:0]          i_idle,
  input  logic [TAPWIDTH-1:0]          i_tap,
  output logic [NUMLANES*SYMWIDTH-1:0] o_sym,
  output logic [NUMLANES-1:0]          o_idle
);

  logic [NUMLANES*SYMWIDTH-1:0] r_sym  [MAXDELAY];
  logic [NUMLANES-1:0]          r_idle [MAXDELAY];
  logic [NUMLANES*SYMWIDTH-1:0] w_sym_in  [MAXDELAY];
  logic [NUMLANES-1:0]          w_idle_in [MAXDELAY];
  logic [NUMLANES*SYMWIDTH-1:0] w_tap_sym;
  logic [NUMLANES-1:0]          w_tap_idle;

  genvar gi;
  generate
    for (gi = 0; gi < MAXDELAY; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign w_sym_in[gi]  = i_sym;
        assign w_idle_in[gi] = i_idle;
      end else begin : g_next
        assign w_sym_in[gi]  = r_sym[gi-1];
        assign w_idle_in[gi] = r_idle[gi-1];
      end

      // Reset leaves every stage looking like an idle lane.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sym[gi]  <= '0;
          r_idle[gi] <= '1;
        end else begin
          r_sym[gi]  <= w_sym_in[gi];
          r_idle[gi] <= w_idle_in[gi];
        end
      end
    end
  endgenerate

  // Tap mux: a tap change takes effect in the same cycle.
  always_comb begin
    w_tap_sym  = r_sym[0];
    w_tap_idle = r_idle[0];
    for (int k = 1; k < MAXDELAY; k++) begin
      if (i_tap == TAPWIDTH'(k)) begin
        w_tap_sym  = r_sym[k];
        w_tap_idle = r_idle[k];
      end
    end
  end

  generate
    for (gi = 0; gi < NUMLANES; gi++) begin : g_lane_out
      assign o_sym[gi*SYMWIDTH +: SYMWIDTH] =
        w_tap_idle[gi] ? IDLE_SYM : w_tap_sym[gi*SYMWIDTH +: SYMWIDTH];
    end
  endgenerate

  assign o_idle = w_tap_idle;

endmodule

// File: rtl/pcie_link_channel.sv
// Bidirectional PCIe link channel model: per-lane polarity inversion, optional
// lane reversal, single-bit error injection and a programmable delay.
//   Clk, notReset                    : clock, asynchronous active-low reset
//   DownIn/DownOut, UpIn/UpOut       : NUMLANES x 10-bit symbols per direction
//   ElecIdle{Down,Up}{In,Out}        : per-lane electrical idle
//   Delay                            : latency in cycles, clamped to 1..MAXDELAY
//   LaneReverse                      : lane i -> lane NUMLANES-1-i, both directions
//   InvertPolarity{Down,Up}          : per-input-lane 10-bit inversion
//   InjErrReq/InjErrDir/InjErrLane   : injection request, direction (1=up), lane
//   InjErrAck                        : one-cycle acknowledge (INJECT state)
//   InjCount                         : saturating count of applied bit flips
module pcie_link_channel
  import pcie_link_pkg::*;
#(
  parameter int NUMLANES = 16,
  parameter int MAXDELAY = MAXDELAY_DEFAULT,
  parameter int CNTWIDTH = 16
) (
  input  logic                         Clk,
  input  logic                         notReset,
  input  logic [NUMLANES*SYMWIDTH-1:0] DownIn,
  output logic [NUMLANES*SYMWIDTH-1:0] DownOut,
  input  logic [NUMLANES*SYMWIDTH-1:0] UpIn,
  output logic [NUMLANES*SYMWIDTH-1:0] UpOut,
  input  logic [NUMLANES-1:0]          ElecIdleDownIn,
  input  logic [NUMLANES-1:0]          ElecIdleUpIn,
  output logic [NUMLANES-1:0]          ElecIdleDownOut,
  output logic [NUMLANES-1:0]          ElecIdleUpOut,
  input  logic [4:0]                   Delay,
  input  logic                         LaneReverse,
  input  logic [NUMLANES-1:0]          InvertPolarityDown,
  input  logic [NUMLANES-1:0]          InvertPolarityUp,
  input  logic                         InjErrReq,
  input  logic                         InjErrDir,
  input  logic [3:0]                   InjErrLane,
  output logic                         InjErrAck,
  output logic [CNTWIDTH-1:0]          InjCount
);

  localparam int W = NUMLANES * SYMWIDTH;

  inj_state_t          r_state;
  inj_state_t          w_state_next;
  logic                w_inj_active;
  logic                r_inj_dir;
  logic [3:0]          r_inj_lane;
  logic [CNTWIDTH-1:0] r_inj_count;
  logic [TAPWIDTH-1:0] w_tap;

  logic [W-1:0]        w_down_inv, w_up_inv;
  logic [W-1:0]        w_down_rev, w_up_rev;
  logic [NUMLANES-1:0] w_down_rev_idle, w_up_rev_idle;
  logic [NUMLANES-1:0] w_down_flip, w_up_flip;
  logic [W-1:0]        w_down_stage0, w_up_stage0;
  logic                w_inj_hit;

  // Delay of 0 still means one register stage; tap index is D-1.
  always_comb begin
    if (Delay == 5'd0)
      w_tap = '0;
    else if (Delay > 5'(MAXDELAY))
      w_tap = TAPWIDTH'(MAXDELAY - 1);
    else
      w_tap = Delay - 5'd1;
  end

  // Inversion is keyed by input lane; reversal then picks the source lane.
  // The flip targets the post-reversal lane and is suppressed on idle lanes.
  genvar gi;
  generate
    for (gi = 0; gi < NUMLANES; gi++) begin : g_lane
      localparam int SRC = NUMLANES - 1 - gi;

      assign w_down_inv[gi*SYMWIDTH +: SYMWIDTH] =
        DownIn[gi*SYMWIDTH +: SYMWIDTH] ^ {SYMWIDTH{InvertPolarityDown[gi]}};
      assign w_up_inv[gi*SYMWIDTH +: SYMWIDTH] =
        UpIn[gi*SYMWIDTH +: SYMWIDTH] ^ {SYMWIDTH{InvertPolarityUp[gi]}};

      assign w_down_rev[gi*SYMWIDTH +: SYMWIDTH] = LaneReverse ?
        w_down_inv[SRC*SYMWIDTH +: SYMWIDTH] : w_down_inv[gi*SYMWIDTH +: SYMWIDTH];
      assign w_up_rev[gi*SYMWIDTH +: SYMWIDTH] = LaneReverse ?
        w_up_inv[SRC*SYMWIDTH +: SYMWIDTH] : w_up_inv[gi*SYMWIDTH +: SYMWIDTH];
      assign w_down_rev_idle[gi] = LaneReverse ? ElecIdleDownIn[SRC] : ElecIdleDownIn[gi];
      assign w_up_rev_idle[gi]   = LaneReverse ? ElecIdleUpIn[SRC]   : ElecIdleUpIn[gi];

      assign w_down_flip[gi] = w_inj_active && !r_inj_dir &&
                               (r_inj_lane == 4'(gi)) && !w_down_rev_idle[gi];
      assign w_up_flip[gi]   = w_inj_active && r_inj_dir &&
                               (r_inj_lane == 4'(gi)) && !w_up_rev_idle[gi];

      assign w_down_stage0[gi*SYMWIDTH +: SYMWIDTH] =
        w_down_rev[gi*SYMWIDTH +: SYMWIDTH] ^ {{(SYMWIDTH-1){1'b0}}, w_down_flip[gi]};
      assign w_up_stage0[gi*SYMWIDTH +: SYMWIDTH] =
        w_up_rev[gi*SYMWIDTH +: SYMWIDTH] ^ {{(SYMWIDTH-1){1'b0}}, w_up_flip[gi]};
    end
  endgenerate

  // Out-of-range lanes never match any flip bit, so this covers both
  // "lane >= NUMLANES" and "target idle".
  assign w_inj_hit = (|w_down_flip) | (|w_up_flip);

  always_ff @(posedge Clk or negedge notReset) begin
    if (!notReset)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_inj_active = 1'b0;
    case (r_state)
      ST_IDLE:   if (InjErrReq) w_state_next = ST_INJECT;
      ST_INJECT: begin
        w_inj_active = 1'b1;
        w_state_next = ST_WAIT;
      end
      ST_WAIT:   if (!InjErrReq) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Target is latched on request acceptance and held through WAIT.
  always_ff @(posedge Clk or negedge notReset) begin
    if (!notReset) begin
      r_inj_dir  <= 1'b0;
      r_inj_lane <= '0;
    end else if (r_state == ST_IDLE && InjErrReq) begin
      r_inj_dir  <= InjErrDir;
      r_inj_lane <= InjErrLane;
    end
  end

  always_ff @(posedge Clk or negedge notReset) begin
    if (!notReset)
      r_inj_count <= '0;
    else if (w_inj_hit && r_inj_count != '1)
      r_inj_count <= r_inj_count + CNTWIDTH'(1);
  end

  assign InjErrAck = w_inj_active;
  assign InjCount  = r_inj_count;

  pcie_link_delay_line #(
    .NUMLANES (NUMLANES),
    .MAXDELAY (MAXDELAY)
  ) u_down (
    .clk    (Clk),
    .rst_n  (notReset),
    .i_sym  (w_down_stage0),
    .i_idle (w_down_rev_idle),
    .i_tap  (w_tap),
    .o_sym  (DownOut),
    .o_idle (ElecIdleDownOut)
  );

  pcie_link_delay_line #(
    .NUMLANES (NUMLANES),
    .MAXDELAY (MAXDELAY)
  ) u_up (
    .clk    (Clk),
    .rst_n  (notReset),
    .i_sym  (w_up_stage0),
    .i_idle (w_up_rev_idle),
    .i_tap  (w_tap),
    .o_sym  (UpOut),
    .o_idle (ElecIdleUpOut)
  );

endmodule

// File: tb/tb_pcie_link_channel.sv
// Directed bench for pcie_link_channel: an 8-lane instance for latency, idle,
// injection and reset, and a 4-lane instance for reversal/inversion.
module tb_pcie_link_channel;

  localparam int NL  = 8;
  localparam int NL4 = 4;

  logic Clk = 1'b0;
  logic notReset;
  always #5 Clk = ~Clk;

  // 8-lane instance
  logic [NL*10-1:0] DownIn, DownOut, UpIn, UpOut;
  logic [NL-1:0]    ElecIdleDownIn, ElecIdleUpIn, ElecIdleDownOut, ElecIdleUpOut;
  logic [NL-1:0]    InvertPolarityDown, InvertPolarityUp;
  logic [4:0]       Delay;
  logic             LaneReverse, InjErrReq, InjErrDir, InjErrAck;
  logic [3:0]       InjErrLane;
  logic [15:0]      InjCount;

  // 4-lane instance
  logic [NL4*10-1:0] DownIn4, DownOut4, UpIn4, UpOut4;
  logic [NL4-1:0]    EIDownIn4, EIUpIn4, EIDownOut4, EIUpOut4, InvDown4, InvUp4;
  logic [4:0]        Delay4;
  logic              LaneRev4, Req4, Dir4, Ack4;
  logic [3:0]        Lane4;
  logic [15:0]       Count4;

  pcie_link_channel #(.NUMLANES(NL), .MAXDELAY(8), .CNTWIDTH(16)) u_dut (
    .Clk(Clk), .notReset(notReset),
    .DownIn(DownIn), .DownOut(DownOut), .UpIn(UpIn), .UpOut(UpOut),
    .ElecIdleDownIn(ElecIdleDownIn), .ElecIdleUpIn(ElecIdleUpIn),
    .ElecIdleDownOut(ElecIdleDownOut), .ElecIdleUpOut(ElecIdleUpOut),
    .Delay(Delay), .LaneReverse(LaneReverse),
    .InvertPolarityDown(InvertPolarityDown), .InvertPolarityUp(InvertPolarityUp),
    .InjErrReq(InjErrReq), .InjErrDir(InjErrDir), .InjErrLane(InjErrLane),
    .InjErrAck(InjErrAck), .InjCount(InjCount)
  );

  pcie_link_channel #(.NUMLANES(NL4), .MAXDELAY(8), .CNTWIDTH(16)) u_dut4 (
    .Clk(Clk), .notReset(notReset),
    .DownIn(DownIn4), .DownOut(DownOut4), .UpIn(UpIn4), .UpOut(UpOut4),
    .ElecIdleDownIn(EIDownIn4), .ElecIdleUpIn(EIUpIn4),
    .ElecIdleDownOut(EIDownOut4), .ElecIdleUpOut(EIUpOut4),
    .Delay(Delay4), .LaneReverse(LaneRev4),
    .InvertPolarityDown(InvDown4), .InvertPolarityUp(InvUp4),
    .InjErrReq(Req4), .InjErrDir(Dir4), .InjErrLane(Lane4),
    .InjErrAck(Ack4), .InjCount(Count4)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Returns cycles from presenting 10'h17C on lane0 to seeing it on DownOut.
  task automatic measure(input logic [4:0] dly, output int lat);
    Delay  = dly;
    DownIn = '0;
    repeat (10) tick();
    DownIn[9:0] = 10'h17C;
    lat = 99;
    for (int n = 1; n <= 20; n++) begin
      tick();
      DownIn[9:0] = 10'h000;
      if (DownOut[9:0] == 10'h17C) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int bad;
    logic ack_seen;

    notReset = 1'b0;
    DownIn = '0; UpIn = '0;
    ElecIdleDownIn = '1; ElecIdleUpIn = '1;
    InvertPolarityDown = '0; InvertPolarityUp = '0;
    Delay = 5'd3; LaneReverse = 1'b0;
    InjErrReq = 1'b0; InjErrDir = 1'b0; InjErrLane = '0;
    DownIn4 = 40'h0; DownIn4[9:0] = 10'h283;
    UpIn4 = 40'h0; UpIn4[19:10] = 10'h111;
    EIDownIn4 = '0; EIUpIn4 = '0;
    InvDown4 = 4'b0001; InvUp4 = '0;
    Delay4 = 5'd1; LaneRev4 = 1'b1;
    Req4 = 1'b0; Dir4 = 1'b0; Lane4 = '0;

    #22;
    check_eq("rst_downout", 32'(DownOut[31:0]), 32'h0);
    check_eq("rst_upout", 32'(UpOut[31:0]), 32'h0);
    check_eq("rst_idle_dn", 32'(ElecIdleDownOut), 32'hFF);
    check_eq("rst_idle_up", 32'(ElecIdleUpOut), 32'hFF);
    check_eq("rst_ack", 32'(InjErrAck), 32'h0);
    check_eq("rst_count", 32'(InjCount), 32'h0);

    @(negedge Clk);
    notReset = 1'b1;
    ElecIdleDownIn = '0; ElecIdleUpIn = '0;
    repeat (4) tick();

    // reversal + inversion on the 4-lane instance
    check_eq("rev_inv_lane3", 32'(DownOut4[39:30]), 32'h17C);
    check_eq("rev_inv_lane0", 32'(DownOut4[9:0]), 32'h000);
    check_eq("rev_up_lane2", 32'(UpOut4[29:20]), 32'h111);

    // latency and Delay clamping
    measure(5'd3, lat);  check_eq("latency_d3", 32'(lat), 32'd3);
    measure(5'd0, lat);  check_eq("latency_d0", 32'(lat), 32'd1);
    measure(5'd31, lat); check_eq("latency_d31", 32'(lat), 32'd8);

    // idle lane masks data
    Delay = 5'd2;
    DownIn = '0;
    DownIn[19:10] = 10'h3FF;
    DownIn[9:0]   = 10'h155;
    ElecIdleDownIn = 8'b0000_0010;
    repeat (2) tick();
    check_eq("idle_sym_l1", 32'(DownOut[19:10]), 32'h000);
    check_eq("idle_flag_l1", 32'(ElecIdleDownOut[1]), 32'h1);
    check_eq("idle_sym_l0", 32'(DownOut[9:0]), 32'h155);
    check_eq("idle_flag_l0", 32'(ElecIdleDownOut[0]), 32'h0);
    DownIn = '0;
    ElecIdleDownIn = '0;

    // applied injection, up direction, lane 2, D=2
    UpIn = '0;
    UpIn[29:20] = 10'h0F0;
    repeat (6) tick();
    InjErrDir = 1'b1; InjErrLane = 4'd2; InjErrReq = 1'b1;
    tick();
    check_eq("inj_ack_on", 32'(InjErrAck), 32'h1);
    check_eq("inj_count_pre", 32'(InjCount), 32'h0);
    tick();
    check_eq("inj_ack_off", 32'(InjErrAck), 32'h0);
    check_eq("inj_count_post", 32'(InjCount), 32'h1);
    check_eq("inj_up_before", 32'(UpOut[29:20]), 32'h0F0);
    tick();
    check_eq("inj_up_flipped", 32'(UpOut[29:20]), 32'h0F1);
    check_eq("inj_down_clean", 32'(DownOut[29:20]), 32'h000);
    tick();
    check_eq("inj_up_after", 32'(UpOut[29:20]), 32'h0F0);
    ack_seen = 1'b0;
    InjErrLane = 4'd3;
    repeat (3) begin
      tick();
      ack_seen = ack_seen | InjErrAck;
    end
    check_eq("inj_no_reack", 32'(ack_seen), 32'h0);
    InjErrReq = 1'b0;
    repeat (2) tick();
    UpIn = '0;

    // ignored injection: lane 15 does not exist
    DownIn = '0;
    DownIn[79:70] = 10'h2AA;
    repeat (4) tick();
    InjErrDir = 1'b0; InjErrLane = 4'd15; InjErrReq = 1'b1;
    tick();
    check_eq("ign_ack_on", 32'(InjErrAck), 32'h1);
    InjErrReq = 1'b0;
    bad = 0;
    repeat (5) begin
      tick();
      if (DownOut[79:70] != 10'h2AA) bad++;
    end
    check_eq("ign_data", 32'(bad), 32'd0);
    check_eq("ign_count", 32'(InjCount), 32'h1);

    // injection into an idle lane: ack but no count
    ElecIdleDownIn = 8'b0000_0010;
    InjErrDir = 1'b0; InjErrLane = 4'd1; InjErrReq = 1'b1;
    tick();
    check_eq("idle_inj_ack", 32'(InjErrAck), 32'h1);
    InjErrReq = 1'b0;
    repeat (3) tick();
    check_eq("idle_inj_count", 32'(InjCount), 32'h1);
    ElecIdleDownIn = '0;
    repeat (4) tick();

    // reset during INJECT
    InjErrDir = 1'b1; InjErrLane = 4'd2; InjErrReq = 1'b1;
    UpIn[29:20] = 10'h0F0;
    tick();
    check_eq("rst_mid_ack_pre", 32'(InjErrAck), 32'h1);
    #2 notReset = 1'b0;
    #1;
    check_eq("rst_mid_ack", 32'(InjErrAck), 32'h0);
    check_eq("rst_mid_count", 32'(InjCount), 32'h0);
    check_eq("rst_mid_upout", 32'(UpOut[29:20]), 32'h0);
    check_eq("rst_mid_downout", 32'(DownOut[79:70]), 32'h0);
    check_eq("rst_mid_idle_dn", 32'(ElecIdleDownOut), 32'hFF);
    check_eq("rst_mid_idle_up", 32'(ElecIdleUpOut), 32'hFF);
    InjErrReq = 1'b0;
    repeat (2) tick();
    notReset = 1'b1;
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
